// File: rtl/bus_generator_arbiter.sv
// rtl/bus_generator_arbiter.sv - shared-bus generator/arbiter, one round-robin FSM per lane
// Each lane pops one packet from a device and routes it by its top address byte.
module bus_generator_arbiter #(
  parameter int          bits      = 1,
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [bits-1:0][drvrs-1:0]               pndng,
  output logic [bits-1:0][drvrs-1:0]               pop,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
  output logic [bits-1:0][drvrs-1:0]               push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);

  localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ROUTE = 1'b1
  } state_t;

  for (genvar b = 0; b < bits; b++) begin : g_lane
    state_t             r_state;
    state_t             w_state_nxt;
    logic [PW-1:0]      r_last;
    logic [PW-1:0]      w_last_nxt;
    logic [PW-1:0]      w_src;
    logic               w_found;
    int                 w_idx;
    logic [pckg_sz-1:0] r_pkt;
    logic [pckg_sz-1:0] w_pkt_nxt;
    logic [pckg_sz-1:0] r_dpush;
    logic [pckg_sz-1:0] w_dpush_nxt;
    logic [drvrs-1:0]   r_pop;
    logic [drvrs-1:0]   w_pop_nxt;
    logic [drvrs-1:0]   r_push;
    logic [drvrs-1:0]   w_push_nxt;
    logic [7:0]         w_dest;

    assign w_dest = r_pkt[pckg_sz-1 -: 8];

    // Round-robin search starting one past the last grant, wrapping at drvrs.
    always_comb begin
      w_idx   = 0;
      w_found = 1'b0;
      w_src   = '0;
      for (int i = 1; i <= drvrs; i++) begin
        w_idx = int'(r_last) + i;
        if (w_idx >= drvrs) begin
          w_idx = w_idx - drvrs;
        end
        if (!w_found && pndng[b][w_idx]) begin
          w_found = 1'b1;
          w_src   = PW'(w_idx);
        end
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_pkt_nxt   = r_pkt;
      w_dpush_nxt = r_dpush;
      w_pop_nxt   = '0;
      w_push_nxt  = '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            w_pop_nxt[w_src] = 1'b1;
            w_pkt_nxt        = D_pop[b][w_src];
            w_last_nxt       = w_src;
            w_state_nxt      = ST_ROUTE;
          end
        end
        ST_ROUTE: begin
          // r_last still holds the sender of the packet in flight.
          w_dpush_nxt = r_pkt;
          if (w_dest == broadcast) begin
            w_push_nxt         = '1;
            w_push_nxt[r_last] = 1'b0;
          end else if (int'(w_dest) < drvrs) begin
            w_push_nxt[int'(w_dest)] = 1'b1;
          end
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_last  <= '0;
        r_pkt   <= '0;
        r_dpush <= '0;
        r_pop   <= '0;
        r_push  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_last  <= w_last_nxt;
        r_pkt   <= w_pkt_nxt;
        r_dpush <= w_dpush_nxt;
        r_pop   <= w_pop_nxt;
        r_push  <= w_push_nxt;
      end
    end

    assign pop[b]  = r_pop;
    assign push[b] = r_push;
    for (genvar j = 0; j < drvrs; j++) begin : g_dout
      assign D_push[b][j] = r_dpush;
    end
  end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// tb/tb_bus_generator_arbiter.sv - scoreboard bench for bus_generator_arbiter
// Device FIFOs are modelled in the bench; a monitor checks every pop/push against the expected queue.
module tb_bus_generator_arbiter;
  localparam int BITS = 1;
  localparam int DRV  = 6;
  localparam int PSZ  = 16;

  logic clk = 1'b0;
  logic reset;
  logic [BITS-1:0][DRV-1:0]          pndng;
  logic [BITS-1:0][DRV-1:0]          pop;
  logic [BITS-1:0][DRV-1:0][PSZ-1:0] D_pop;
  logic [BITS-1:0][DRV-1:0]          push;
  logic [BITS-1:0][DRV-1:0][PSZ-1:0] D_push;

  bus_generator_arbiter #(
    .bits(BITS), .drvrs(DRV), .pckg_sz(PSZ), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .pop(pop),
    .D_pop(D_pop), .push(push), .D_push(D_push)
  );

  always #5 clk = ~clk;

  typedef struct { int dev; logic [15:0] data; } tx_t;
  typedef struct { bit is_push; logic [5:0] vec; logic [15:0] data; int gap; } ev_t;

  tx_t txq[$];
  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  last_cyc = 0;

  task automatic drive_inputs();
    logic [DRV-1:0]          p;
    logic [DRV-1:0][PSZ-1:0] d;
    p = '0;
    d = '0;
    for (int i = txq.size() - 1; i >= 0; i--) begin
      p[txq[i].dev] = 1'b1;
      d[txq[i].dev] = txq[i].data;
    end
    pndng[0] = p;
    D_pop[0] = d;
  endtask

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(int dev, logic [15:0] data);
    tx_t t;
    t.dev  = dev;
    t.data = data;
    txq.push_back(t);
    drive_inputs();
  endtask

  task automatic expect_ev(bit is_push, logic [5:0] vec, logic [15:0] data, int gap);
    ev_t e;
    e.is_push = is_push;
    e.vec     = vec;
    e.data    = data;
    e.gap     = gap;
    exp_q.push_back(e);
  endtask

  task automatic handle(bit is_push, logic [5:0] vec);
    ev_t e;
    bit  ok;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s vec=%b cycle %0d, expected none",
               is_push ? "push" : "pop", vec, cyc);
      return;
    end
    e  = exp_q.pop_front();
    ok = 1'b1;
    if (e.is_push != is_push || e.vec !== vec) ok = 1'b0;
    if (e.gap != 0 && (cyc - last_cyc) != e.gap) ok = 1'b0;
    if (is_push) begin
      for (int j = 0; j < DRV; j++) begin
        if (D_push[0][j] !== e.data) ok = 1'b0;
      end
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL event: got %s vec=%b gap=%0d data0=%h, expected %s vec=%b gap=%0d data=%h",
               is_push ? "push" : "pop", vec, cyc - last_cyc, D_push[0][0],
               e.is_push ? "push" : "pop", e.vec, e.gap, e.data);
    end
    last_cyc = cyc;
  endtask

  // Device FIFO model: the head is dequeued during the cycle its pop strobe is seen.
  always @(negedge clk) begin
    if (!reset && pop[0] != '0) begin
      for (int d = 0; d < DRV; d++) begin
        if (pop[0][d]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < txq.size(); i++) begin
            if (idx < 0 && txq[i].dev == d) idx = i;
          end
          if (idx >= 0) txq.delete(idx);
        end
      end
      drive_inputs();
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      if (pop[0] != '0 && push[0] != '0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_push_excl: got pop=%b push=%b, expected not both", pop[0], push[0]);
      end
      if (pop[0] != '0) handle(1'b0, pop[0]);
      if (push[0] != '0) handle(1'b1, push[0]);
    end
  end

  task automatic drain(string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1;
    pndng = '0;
    D_pop = '0;
    #2;
    check("rst_pop", pop, 0);
    check("rst_push", push, 0);
    check("rst_dpush", D_push, 0);
    #18;
    check("rst_pop_end", pop, 0);
    check("rst_dpush_end", D_push, 0);
    #2 reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_pop", pop, 0);
    check("idle_push", push, 0);

    // Unicast dev1 -> dev3
    send(1, 16'h03AB);
    expect_ev(1'b0, 6'b000010, 16'h0, 0);
    expect_ev(1'b1, 6'b001000, 16'h03AB, 1);
    drain("unicast_drain");
    check("dpush_hold0", D_push[0][0], 16'h03AB);
    check("dpush_hold5", D_push[0][5], 16'h03AB);
    check("push_idle", push, 0);

    // Broadcast from dev2
    send(2, 16'hFF55);
    expect_ev(1'b0, 6'b000100, 16'h0, 0);
    expect_ev(1'b1, 6'b111011, 16'hFF55, 1);
    drain("bcast_drain");

    // Bring last_grant to 0, then devices 0,2,5 pending continuously
    send(0, 16'h0101);
    expect_ev(1'b0, 6'b000001, 16'h0, 0);
    expect_ev(1'b1, 6'b000010, 16'h0101, 1);
    drain("rr_prep_drain");
    send(0, 16'h0510); send(0, 16'h0511);
    send(2, 16'h0020); send(2, 16'h0021);
    send(5, 16'h0150); send(5, 16'h0151);
    expect_ev(1'b0, 6'b000100, 16'h0, 0);
    expect_ev(1'b1, 6'b000001, 16'h0020, 1);
    expect_ev(1'b0, 6'b100000, 16'h0, 1);
    expect_ev(1'b1, 6'b000010, 16'h0150, 1);
    expect_ev(1'b0, 6'b000001, 16'h0, 1);
    expect_ev(1'b1, 6'b100000, 16'h0510, 1);
    expect_ev(1'b0, 6'b000100, 16'h0, 1);
    expect_ev(1'b1, 6'b000001, 16'h0021, 1);
    expect_ev(1'b0, 6'b100000, 16'h0, 1);
    expect_ev(1'b1, 6'b000010, 16'h0151, 1);
    expect_ev(1'b0, 6'b000001, 16'h0, 1);
    expect_ev(1'b1, 6'b100000, 16'h0511, 1);
    drain("rr_drain");

    // Invalid destination: pop only, nothing delivered
    send(4, 16'h0912);
    expect_ev(1'b0, 6'b010000, 16'h0, 0);
    drain("invalid_drain");

    // Destination equals sender
    send(3, 16'h0333);
    expect_ev(1'b0, 6'b001000, 16'h0, 0);
    expect_ev(1'b1, 6'b001000, 16'h0333, 1);
    drain("self_drain");

    // Reset in the cycle after the pop strobe, before delivery
    send(3, 16'h0011);
    expect_ev(1'b0, 6'b001000, 16'h0, 0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pop[0][3]) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_pop_seen", found, 1);
    #1 reset = 1'b1;
    #1;
    check("midrst_push", push, 0);
    check("midrst_pop", pop, 0);
    check("midrst_dpush", D_push, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    drain("midrst_drain");

    // Pointer back at 0: dev2 wins over dev4
    send(2, 16'h0422);
    send(4, 16'h0044);
    expect_ev(1'b0, 6'b000100, 16'h0, 0);
    expect_ev(1'b1, 6'b010000, 16'h0422, 1);
    expect_ev(1'b0, 6'b010000, 16'h0, 1);
    expect_ev(1'b1, 6'b000001, 16'h0044, 1);
    drain("ptr_drain");

    check("final_txq_empty", txq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
